reset_sequencer: RTL and testbench

- Parametrised, clocked successor to the combinational CPU reset/context-exchange controller. Sits between the control unit, the OS scheduler logic and the CPU core.
- Qualifies reset requests and stretches each into a programmable-length `resetCPU` pulse.
- Owns an internal quantum (watchdog) down-counter.
- Issues a held `jump_context_exchange` request until the scheduler acknowledges it.

---
 rtl/galetron_pkg.sv | 39 +++
 rtl/quantum_timer.sv | 35 +++
 rtl/reset_sequencer.sv | 148 ++++++++++++++
 tb/tb_reset_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/galetron_pkg.sv
// Shared constants and encodings for the galetron reset/context-exchange path.
// Opcode values, FSM state encoding and reset-cause encoding live here.
package galetron_pkg;

  // Opcode that asks the core to (re)start the whole system.
  localparam logic [5:0] OPC_START = 6'b100111;

  // Default geometry of the sequencer.
  localparam int DEF_OP_WIDTH      = 6;
  localparam int DEF_PC_WIDTH      = 12;
  localparam int DEF_OS_PC_LIMIT   = 256;
  localparam int DEF_RESET_CYCLES  = 4;
  localparam int DEF_QUANTUM_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_START  = 2'd1,
    CAUSE_SYSRST = 2'd2,
    CAUSE_RESUME = 2'd3
  } cause_t;

  // Highest-priority active source; only meaningful while a request is present.
  function automatic cause_t pick_cause(input logic start, input logic sysrst);
    if (start) begin
      return CAUSE_START;
    end else if (sysrst) begin
      return CAUSE_SYSRST;
    end else begin
      return CAUSE_RESUME;
    end
  endfunction

endpackage

// File: rtl/quantum_timer.sv
// Saturating quantum (watchdog) down-counter with load priority.
// o_expire pulses combinationally on the cycle whose edge takes the count 1->0.
module quantum_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;
  logic             w_dec;

  // A load on the would-be expiry cycle wins, so it also suppresses expiry.
  assign w_dec    = !i_load && i_enable && (r_count != '0);
  assign o_expire = w_dec && (r_count == WIDTH'(1));
  assign o_count  = r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (w_dec) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Qualifies CPU reset requests into a fixed-length resetCPU pulse and issues a
// held jump-to-scheduler request on quantum expiry or software context switch.
module reset_sequencer
  import galetron_pkg::*;
#(
  parameter int                  OP_WIDTH      = DEF_OP_WIDTH,
  parameter int                  PC_WIDTH      = DEF_PC_WIDTH,
  parameter int                  OS_PC_LIMIT   = DEF_OS_PC_LIMIT,
  parameter logic [OP_WIDTH-1:0] START_OPCODE  = OPC_START,
  parameter int                  RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int                  QUANTUM_WIDTH = DEF_QUANTUM_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [OP_WIDTH-1:0]      operation,
  input  logic [PC_WIDTH-1:0]      program_counter,
  input  logic                     system_reset,
  input  logic                     resume_os,
  input  logic                     context_exchange,
  input  logic                     quantum_load,
  input  logic [QUANTUM_WIDTH-1:0] quantum_value,
  input  logic                     quantum_enable,
  input  logic                     context_ack,
  output logic                     resetCPU,
  output logic                     jump_context_exchange,
  output logic [1:0]               reset_cause,
  output logic [QUANTUM_WIDTH-1:0] quantum_count
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [PC_WIDTH:0]   PC_LIMIT  = (PC_WIDTH + 1)'(OS_PC_LIMIT);

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_reset_cpu;
  logic                r_jump;
  cause_t              r_cause;
  logic                r_switch_pending;

  logic                w_is_start;
  logic                w_in_os;
  logic                w_rst_req;
  cause_t              w_cause;
  logic [QUANTUM_WIDTH-1:0] w_count;
  logic                w_expire;
  logic                w_pend_set;

  // Unsigned compare over the full PC width; the extra MSB keeps a limit of
  // 2**PC_WIDTH representable.
  assign w_is_start = (operation == START_OPCODE);
  assign w_in_os    = ({1'b0, program_counter} < PC_LIMIT);
  assign w_rst_req  = w_is_start | system_reset | (resume_os & w_in_os);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_cause = CAUSE_NONE;
    if (w_rst_req) begin
      w_cause = pick_cause(w_is_start, system_reset);
    end
  end

  quantum_timer #(
    .WIDTH(QUANTUM_WIDTH)
  ) u_quantum_timer (
    .clock    (clock),
    .reset    (reset),
    .i_load   (quantum_load),
    .i_value  (quantum_value),
    .i_enable (quantum_enable && (r_state == ST_RUN)),
    .o_count  (w_count),
    .o_expire (w_expire)
  );

  // A zero quantum blocks software switches as well as expiry.
  assign w_pend_set = w_expire | (context_exchange & (w_count != '0));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_RUN;
      r_hold           <= '0;
      r_reset_cpu      <= 1'b0;
      r_jump           <= 1'b0;
      r_cause          <= CAUSE_NONE;
      r_switch_pending <= 1'b0;
    end else begin
      // Set first; any clear in the state logic below overrides it, so a
      // reset or an ack always beats a same-cycle new switch request.
      if (w_pend_set) begin
        r_switch_pending <= 1'b1;
      end

      case (r_state)
        ST_RUN: begin
          if (w_rst_req) begin
            r_state          <= ST_HOLD;
            r_hold           <= HOLD_LOAD;
            r_reset_cpu      <= 1'b1;
            r_cause          <= w_cause;
            r_switch_pending <= 1'b0;
          end else if (r_switch_pending) begin
            r_state <= ST_SWITCH;
            r_jump  <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (r_hold != '0) begin
            r_hold <= r_hold - HOLD_W'(1);
          end else if (w_rst_req) begin
            r_hold <= HOLD_LOAD;
          end else begin
            r_state     <= ST_RUN;
            r_reset_cpu <= 1'b0;
          end
        end

        ST_SWITCH: begin
          if (w_rst_req) begin
            r_state          <= ST_HOLD;
            r_hold           <= HOLD_LOAD;
            r_reset_cpu      <= 1'b1;
            r_jump           <= 1'b0;
            r_cause          <= w_cause;
            r_switch_pending <= 1'b0;
          end else if (context_ack) begin
            r_state          <= ST_RUN;
            r_jump           <= 1'b0;
            r_switch_pending <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_RUN;
          r_reset_cpu <= 1'b0;
          r_jump      <= 1'b0;
        end
      endcase
    end
  end

  assign resetCPU              = r_reset_cpu;
  assign jump_context_exchange = r_jump;
  assign reset_cause           = r_cause;
  assign quantum_count         = w_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus a randomized
// run compared every cycle against a behavioural model of the sequencing rules.
module tb_reset_sequencer;

  localparam int         RC       = 4;
  localparam int         OS_LIMIT = 256;
  localparam logic [5:0] START_OP = 6'b100111;

  logic        clock;
  logic        reset;
  logic [5:0]  operation;
  logic [11:0] program_counter;
  logic        system_reset;
  logic        resume_os;
  logic        context_exchange;
  logic        quantum_load;
  logic [31:0] quantum_value;
  logic        quantum_enable;
  logic        context_ack;
  logic        resetCPU;
  logic        jump_context_exchange;
  logic [1:0]  reset_cause;
  logic [31:0] quantum_count;

  int checks = 0;
  int errors = 0;

  reset_sequencer dut (
    .clock                 (clock),
    .reset                 (reset),
    .operation             (operation),
    .program_counter       (program_counter),
    .system_reset          (system_reset),
    .resume_os             (resume_os),
    .context_exchange      (context_exchange),
    .quantum_load          (quantum_load),
    .quantum_value         (quantum_value),
    .quantum_enable        (quantum_enable),
    .context_ack           (context_ack),
    .resetCPU              (resetCPU),
    .jump_context_exchange (jump_context_exchange),
    .reset_cause           (reset_cause),
    .quantum_count         (quantum_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: m_rem counts the resetCPU cycles still to come, m_jump
  // is the outstanding scheduler request; "running" means neither is active.
  int          m_rem;
  logic        m_jump;
  logic        m_pend;
  logic [1:0]  m_cause;
  logic [31:0] m_cnt;
  logic        m_req;
  logic        m_run;
  logic        m_dec;
  logic        m_pset;
  logic [1:0]  m_cause_now;

  assign m_req = (operation == START_OP) || system_reset ||
                 (resume_os && (int'(program_counter) < OS_LIMIT));
  assign m_run = (m_rem == 0) && !m_jump;
  assign m_dec = !quantum_load && quantum_enable && m_run && (m_cnt != 32'd0);
  assign m_pset = (m_dec && (m_cnt == 32'd1)) || (context_exchange && (m_cnt != 32'd0));
  assign m_cause_now = (operation == START_OP) ? 2'd1 : (system_reset ? 2'd2 : 2'd3);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_rem   <= 0;
      m_jump  <= 1'b0;
      m_pend  <= 1'b0;
      m_cause <= 2'd0;
      m_cnt   <= 32'd0;
    end else begin
      m_cnt  <= quantum_load ? quantum_value : (m_dec ? m_cnt - 32'd1 : m_cnt);
      m_pend <= m_pend || m_pset;
      if (m_rem > 0) begin
        m_rem <= (m_rem == 1) ? (m_req ? RC : 0) : m_rem - 1;
      end else if (m_req) begin
        m_rem   <= RC;
        m_jump  <= 1'b0;
        m_cause <= m_cause_now;
        m_pend  <= 1'b0;
      end else if (m_jump) begin
        if (context_ack) begin
          m_jump <= 1'b0;
          m_pend <= 1'b0;
        end
      end else if (m_pend) begin
        m_jump <= 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    operation        = 6'd0;
    program_counter  = 12'd1000;
    system_reset     = 1'b0;
    resume_os        = 1'b0;
    context_exchange = 1'b0;
    quantum_load     = 1'b0;
    quantum_value    = 32'd0;
    quantum_enable   = 1'b0;
    context_ack      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    step();
    step();
    checks += 4;
    if (resetCPU !== 1'b0) begin
      errors++; $display("FAIL reset_resetCPU got %0b exp 0", resetCPU);
    end
    if (jump_context_exchange !== 1'b0) begin
      errors++; $display("FAIL reset_jump got %0b exp 0", jump_context_exchange);
    end
    if (reset_cause !== 2'd0) begin
      errors++; $display("FAIL reset_cause got %0d exp 0", reset_cause);
    end
    if (quantum_count !== 32'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", quantum_count);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_start_pulse();
    operation = START_OP;
    for (int k = 1; k <= 7; k++) begin
      step();
      operation = 6'd0;
      checks++;
      if (resetCPU !== ((k <= RC) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL start_pulse cycle %0d got %0b exp %0b", k, resetCPU, (k <= RC));
      end
    end
    checks++;
    if (reset_cause !== 2'd1) begin
      errors++; $display("FAIL start_cause got %0d exp 1", reset_cause);
    end
  endtask

  task automatic test_resume_pc();
    resume_os = 1'b1;
    program_counter = 12'd255;
    step();
    resume_os = 1'b0;
    checks += 2;
    if (resetCPU !== 1'b1) begin
      errors++; $display("FAIL resume255_reset got %0b exp 1", resetCPU);
    end
    if (reset_cause !== 2'd3) begin
      errors++; $display("FAIL resume255_cause got %0d exp 3", reset_cause);
    end
    repeat (RC + 1) step();
    resume_os = 1'b1;
    program_counter = 12'd256;
    step();
    resume_os = 1'b0;
    step();
    checks += 2;
    if (resetCPU !== 1'b0) begin
      errors++; $display("FAIL resume256_reset got %0b exp 0", resetCPU);
    end
    if (reset_cause !== 2'd3) begin
      errors++; $display("FAIL resume256_cause_held got %0d exp 3", reset_cause);
    end
    system_reset = 1'b1;
    resume_os = 1'b1;
    program_counter = 12'd10;
    step();
    system_reset = 1'b0;
    resume_os = 1'b0;
    checks += 2;
    if (resetCPU !== 1'b1) begin
      errors++; $display("FAIL sys_resume_reset got %0b exp 1", resetCPU);
    end
    if (reset_cause !== 2'd2) begin
      errors++; $display("FAIL sys_resume_cause got %0d exp 2", reset_cause);
    end
    repeat (RC + 1) step();
  endtask

  task automatic test_quantum_expiry();
    quantum_load = 1'b1;
    quantum_value = 32'd3;
    quantum_enable = 1'b1;
    step();
    quantum_load = 1'b0;
    for (int v = 3; v >= 0; v--) begin
      checks++;
      if (quantum_count !== 32'(v)) begin
        errors++; $display("FAIL expiry_count got %0d exp %0d", quantum_count, v);
      end
      if (v != 0) step();
    end
    checks++;
    if (jump_context_exchange !== 1'b0) begin
      errors++; $display("FAIL expiry_jump_early got %0b exp 0", jump_context_exchange);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (jump_context_exchange !== 1'b1) begin
        errors++; $display("FAIL expiry_jump_held cycle %0d got %0b exp 1", i, jump_context_exchange);
      end
    end
    context_ack = 1'b1;
    step();
    context_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks += 2;
      if (jump_context_exchange !== 1'b0) begin
        errors++; $display("FAIL expiry_jump_after_ack cycle %0d got %0b exp 0", i, jump_context_exchange);
      end
      if (quantum_count !== 32'd0) begin
        errors++; $display("FAIL expiry_count_after got %0d exp 0", quantum_count);
      end
      step();
    end
    quantum_enable = 1'b0;
  endtask

  task automatic test_ctx_switch();
    context_exchange = 1'b1;
    step();
    context_exchange = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (jump_context_exchange !== 1'b0) begin
        errors++; $display("FAIL ctx_zero_quantum got %0b exp 0", jump_context_exchange);
      end
    end
    quantum_load = 1'b1;
    quantum_value = 32'd10;
    step();
    quantum_load = 1'b0;
    checks++;
    if (quantum_count !== 32'd10) begin
      errors++; $display("FAIL ctx_load got %0d exp 10", quantum_count);
    end
    context_exchange = 1'b1;
    step();
    context_exchange = 1'b0;
    checks++;
    if (jump_context_exchange !== 1'b0) begin
      errors++; $display("FAIL ctx_jump_early got %0b exp 0", jump_context_exchange);
    end
    step();
    checks++;
    if (jump_context_exchange !== 1'b1) begin
      errors++; $display("FAIL ctx_jump got %0b exp 1", jump_context_exchange);
    end
    system_reset = 1'b1;
    step();
    system_reset = 1'b0;
    checks += 3;
    if (jump_context_exchange !== 1'b0) begin
      errors++; $display("FAIL switch_reset_jump got %0b exp 0", jump_context_exchange);
    end
    if (resetCPU !== 1'b1) begin
      errors++; $display("FAIL switch_reset_cpu got %0b exp 1", resetCPU);
    end
    if (reset_cause !== 2'd2) begin
      errors++; $display("FAIL switch_reset_cause got %0d exp 2", reset_cause);
    end
    repeat (RC) step();
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (resetCPU !== 1'b0 || jump_context_exchange !== 1'b0) begin
        errors++;
        $display("FAIL switch_abandoned got rst %0b jump %0b exp 0 0", resetCPU, jump_context_exchange);
      end
      if (quantum_count !== 32'd10) begin
        errors++; $display("FAIL switch_count_kept got %0d exp 10", quantum_count);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_switch();
    quantum_load = 1'b1;
    quantum_value = 32'd1;
    quantum_enable = 1'b1;
    step();
    quantum_load = 1'b0;
    step();
    step();
    quantum_enable = 1'b0;
    checks++;
    if (jump_context_exchange !== 1'b1) begin
      errors++; $display("FAIL midswitch_setup got %0b exp 1", jump_context_exchange);
    end
    #2 reset = 1'b0;
    #1;
    checks += 4;
    if (jump_context_exchange !== 1'b0) begin
      errors++; $display("FAIL async_jump got %0b exp 0", jump_context_exchange);
    end
    if (resetCPU !== 1'b0) begin
      errors++; $display("FAIL async_resetCPU got %0b exp 0", resetCPU);
    end
    if (reset_cause !== 2'd0) begin
      errors++; $display("FAIL async_cause got %0d exp 0", reset_cause);
    end
    if (quantum_count !== 32'd0) begin
      errors++; $display("FAIL async_count got %0d exp 0", quantum_count);
    end
    step();
    reset = 1'b1;
    step();
    step();
    checks += 2;
    if (jump_context_exchange !== 1'b0 || resetCPU !== 1'b0) begin
      errors++;
      $display("FAIL after_release got jump %0b rst %0b exp 0 0", jump_context_exchange, resetCPU);
    end
    if (quantum_count !== 32'd0) begin
      errors++; $display("FAIL after_release_count got %0d exp 0", quantum_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      operation        = ($urandom_range(0, 39) == 0) ? START_OP : 6'($urandom_range(0, 38));
      program_counter  = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(250, 262))
                                                     : 12'($urandom_range(0, 4095));
      system_reset     = ($urandom_range(0, 59) == 0);
      resume_os        = ($urandom_range(0, 24) == 0);
      context_exchange = ($urandom_range(0, 9) == 0);
      quantum_load     = ($urandom_range(0, 19) == 0);
      quantum_value    = 32'($urandom_range(0, 12));
      quantum_enable   = ($urandom_range(0, 7) != 0);
      context_ack      = ($urandom_range(0, 3) == 0);
      step();
      checks += 4;
      if (resetCPU !== (m_rem > 0)) begin
        errors++; $display("FAIL rand_resetCPU cycle %0d got %0b exp %0b", n, resetCPU, (m_rem > 0));
      end
      if (jump_context_exchange !== m_jump) begin
        errors++; $display("FAIL rand_jump cycle %0d got %0b exp %0b", n, jump_context_exchange, m_jump);
      end
      if (reset_cause !== m_cause) begin
        errors++; $display("FAIL rand_cause cycle %0d got %0d exp %0d", n, reset_cause, m_cause);
      end
      if (quantum_count !== m_cnt) begin
        errors++; $display("FAIL rand_count cycle %0d got %0d exp %0d", n, quantum_count, m_cnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_start_pulse();
    test_resume_pc();
    test_quantum_expiry();
    test_ctx_switch();
    test_reset_mid_switch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
